// File: rtl/mem_arbiter.sv
// CPU / program-loader arbiter for a split even/odd byte-lane RAM.
// The loader gets a forced grant after STARVE_LIMIT consecutive waits.
module mem_arbiter #(
    parameter int ADDR_WIDTH   = 13,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cpu_req,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic                  cpu_wr,
    input  logic                  cpu_byt,
    input  logic [15:0]           cpu_wr_data,
    output logic [15:0]           cpu_rd_data,
    output logic                  cpu_stall,
    input  logic                  ldr_req,
    input  logic [ADDR_WIDTH-1:0] ldr_addr,
    input  logic [7:0]            ldr_wr_data,
    output logic                  ldr_ack,
    output logic [ADDR_WIDTH-2:0] addr_lo,
    output logic [ADDR_WIDTH-2:0] addr_hi,
    output logic                  wr_lo,
    output logic                  wr_hi,
    output logic [7:0]            wr_data_lo,
    output logic [7:0]            wr_data_hi,
    input  logic [7:0]            rd_data_lo,
    input  logic [7:0]            rd_data_hi
);

    localparam int CW = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {
        G_NONE,
        G_CPU,
        G_LDR
    } grant_t;

    typedef struct packed {
        logic valid;
        logic byt;
        logic lane;
    } sel_t;

    grant_t        grant;
    sel_t          sel;
    logic [CW-1:0] starve_cnt;
    logic          starved;

    assign starved = ldr_req && (starve_cnt == CW'(STARVE_LIMIT));

    always_comb begin
        grant = G_NONE;
        if (rst)
            grant = G_NONE;
        else if (cpu_req && !starved)
            grant = G_CPU;
        else if (ldr_req)
            grant = G_LDR;
    end

    assign cpu_stall = cpu_req && !rst && (grant != G_CPU);
    assign ldr_ack   = (grant == G_LDR);

    // Idle and read cycles keep the CPU address on both lanes.
    always_comb begin
        addr_lo    = cpu_addr[ADDR_WIDTH-1:1];
        addr_hi    = cpu_addr[ADDR_WIDTH-1:1];
        wr_lo      = 1'b0;
        wr_hi      = 1'b0;
        wr_data_lo = cpu_wr_data[7:0];
        wr_data_hi = cpu_byt ? cpu_wr_data[7:0] : cpu_wr_data[15:8];
        case (grant)
            G_CPU: begin
                if (cpu_wr) begin
                    wr_lo = !cpu_byt || !cpu_addr[0];
                    wr_hi = !cpu_byt || cpu_addr[0];
                end
            end
            G_LDR: begin
                addr_lo    = ldr_addr[ADDR_WIDTH-1:1];
                addr_hi    = ldr_addr[ADDR_WIDTH-1:1];
                wr_data_lo = ldr_wr_data;
                wr_data_hi = ldr_wr_data;
                wr_lo      = !ldr_addr[0];
                wr_hi      = ldr_addr[0];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= '0;
            sel        <= '0;
        end else begin
            sel.valid <= (grant == G_CPU) && !cpu_wr;
            sel.byt   <= cpu_byt;
            sel.lane  <= cpu_addr[0];
            if (grant == G_LDR || !ldr_req)
                starve_cnt <= '0;
            else if (grant == G_CPU && starve_cnt != CW'(STARVE_LIMIT))
                starve_cnt <= starve_cnt + CW'(1);
        end
    end

    always_comb begin
        cpu_rd_data = 16'h0000;
        if (!rst && sel.valid) begin
            unique case (1'b1)
                !sel.byt:            cpu_rd_data = {rd_data_hi, rd_data_lo};
                sel.byt && !sel.lane: cpu_rd_data = {8'h00, rd_data_lo};
                sel.byt && sel.lane:  cpu_rd_data = {8'h00, rd_data_hi};
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed vector bench for mem_arbiter with a byte-lane RAM model.
// Each step drives one cycle and checks outputs before the next edge.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req;
    logic [12:0] cpu_addr;
    logic        cpu_wr;
    logic        cpu_byt;
    logic [15:0] cpu_wr_data;
    logic [15:0] cpu_rd_data;
    logic        cpu_stall;
    logic        ldr_req;
    logic [12:0] ldr_addr;
    logic [7:0]  ldr_wr_data;
    logic        ldr_ack;
    logic [11:0] addr_lo;
    logic [11:0] addr_hi;
    logic        wr_lo;
    logic        wr_hi;
    logic [7:0]  wr_data_lo;
    logic [7:0]  wr_data_hi;
    logic [7:0]  rd_data_lo;
    logic [7:0]  rd_data_hi;

    int tests = 0;
    int fails = 0;

    logic [7:0] ram_lo [0:4095];
    logic [7:0] ram_hi [0:4095];

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk(clk),
        .rst(rst),
        .cpu_req(cpu_req),
        .cpu_addr(cpu_addr),
        .cpu_wr(cpu_wr),
        .cpu_byt(cpu_byt),
        .cpu_wr_data(cpu_wr_data),
        .cpu_rd_data(cpu_rd_data),
        .cpu_stall(cpu_stall),
        .ldr_req(ldr_req),
        .ldr_addr(ldr_addr),
        .ldr_wr_data(ldr_wr_data),
        .ldr_ack(ldr_ack),
        .addr_lo(addr_lo),
        .addr_hi(addr_hi),
        .wr_lo(wr_lo),
        .wr_hi(wr_hi),
        .wr_data_lo(wr_data_lo),
        .wr_data_hi(wr_data_hi),
        .rd_data_lo(rd_data_lo),
        .rd_data_hi(rd_data_hi)
    );

    always @(posedge clk) begin
        if (wr_lo) ram_lo[addr_lo] <= wr_data_lo;
        if (wr_hi) ram_hi[addr_hi] <= wr_data_hi;
        rd_data_lo <= ram_lo[addr_lo];
        rd_data_hi <= ram_hi[addr_hi];
    end

    typedef struct {
        string       name;
        logic        rst;
        logic        creq;
        logic [12:0] caddr;
        logic        cwr;
        logic        cbyt;
        logic [15:0] cwd;
        logic        lreq;
        logic [12:0] laddr;
        logic [7:0]  ld;
        logic        stall;
        logic        ack;
        logic        wl;
        logic        wh;
        logic [11:0] wa;
        logic [7:0]  edl;
        logic [7:0]  edh;
        logic [15:0] rd;
    } vec_t;

    function automatic vec_t mk(
        string n, logic r, logic cq, logic [12:0] ca, logic cw,
        logic cb, logic [15:0] cd, logic lq, logic [12:0] la,
        logic [7:0] ld, logic st, logic ak, logic wl, logic wh,
        logic [11:0] wa, logic [7:0] edl, logic [7:0] edh,
        logic [15:0] rd);
        vec_t v;
        v.name = n;  v.rst = r;   v.creq = cq; v.caddr = ca;
        v.cwr = cw;  v.cbyt = cb; v.cwd = cd;  v.lreq = lq;
        v.laddr = la; v.ld = ld;  v.stall = st; v.ack = ak;
        v.wl = wl;   v.wh = wh;   v.wa = wa;   v.edl = edl;
        v.edh = edh; v.rd = rd;
        return v;
    endfunction

    task automatic chk(input string n, input logic [15:0] act,
                       input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    task automatic step(input vec_t v);
        @(negedge clk);
        rst         = v.rst;
        cpu_req     = v.creq;
        cpu_addr    = v.caddr;
        cpu_wr      = v.cwr;
        cpu_byt     = v.cbyt;
        cpu_wr_data = v.cwd;
        ldr_req     = v.lreq;
        ldr_addr    = v.laddr;
        ldr_wr_data = v.ld;
        #1;
        chk({v.name, " stall"}, 16'(cpu_stall), 16'(v.stall));
        chk({v.name, " ack"}, 16'(ldr_ack), 16'(v.ack));
        chk({v.name, " wr_lo"}, 16'(wr_lo), 16'(v.wl));
        chk({v.name, " wr_hi"}, 16'(wr_hi), 16'(v.wh));
        chk({v.name, " addr_lo"}, 16'(addr_lo), 16'(v.wa));
        chk({v.name, " addr_hi"}, 16'(addr_hi), 16'(v.wa));
        if (v.wl) chk({v.name, " wdata_lo"}, 16'(wr_data_lo), 16'(v.edl));
        if (v.wh) chk({v.name, " wdata_hi"}, 16'(wr_data_hi), 16'(v.edh));
        chk({v.name, " rd_data"}, cpu_rd_data, v.rd);
    endtask

    vec_t tbl [$];
    vec_t v;

    initial begin
        for (int i = 0; i < 4096; i++) begin
            ram_lo[i] = 8'h00;
            ram_hi[i] = 8'h00;
        end
        rst = 1'b1;
        cpu_req = 1'b0; cpu_addr = '0; cpu_wr = 1'b0; cpu_byt = 1'b0;
        cpu_wr_data = '0; ldr_req = 1'b0; ldr_addr = '0; ldr_wr_data = '0;

        tbl.push_back(mk("rst_both", 1, 1, 13'h000, 1, 0, 16'h1234,
                         1, 13'h010, 8'h99, 0, 0, 0, 0, 12'h000, 0, 0, 0));
        tbl.push_back(mk("idle", 0, 0, 13'h000, 0, 0, 0,
                         0, 0, 0, 0, 0, 0, 0, 12'h000, 0, 0, 0));
        tbl.push_back(mk("wwr_beef", 0, 1, 13'h300, 1, 0, 16'hBEEF,
                         0, 0, 0, 0, 0, 1, 1, 12'h180, 8'hEF, 8'hBE, 0));
        tbl.push_back(mk("wrd_300", 0, 1, 13'h300, 0, 0, 0,
                         0, 0, 0, 0, 0, 0, 0, 12'h180, 0, 0, 0));
        tbl.push_back(mk("bwr_301", 0, 1, 13'h301, 1, 1, 16'h005A,
                         0, 0, 0, 0, 0, 0, 1, 12'h180, 0, 8'h5A, 16'hBEEF));
        tbl.push_back(mk("brd_300", 0, 1, 13'h300, 0, 1, 0,
                         0, 0, 0, 0, 0, 0, 0, 12'h180, 0, 0, 0));
        tbl.push_back(mk("brd_301", 0, 1, 13'h301, 0, 1, 0,
                         0, 0, 0, 0, 0, 0, 0, 12'h180, 0, 0, 16'h00EF));
        tbl.push_back(mk("idle2", 0, 0, 13'h000, 0, 0, 0,
                         0, 0, 0, 0, 0, 0, 0, 12'h000, 0, 0, 16'h005A));
        tbl.push_back(mk("ldr_002", 0, 0, 13'h000, 0, 0, 0,
                         1, 13'h002, 8'h11, 0, 1, 1, 0, 12'h001, 8'h11, 0, 0));
        tbl.push_back(mk("ldr_003", 0, 0, 13'h000, 0, 0, 0,
                         1, 13'h003, 8'h22, 0, 1, 0, 1, 12'h001, 0, 8'h22, 0));
        tbl.push_back(mk("wrd_002", 0, 1, 13'h002, 0, 0, 0,
                         0, 0, 0, 0, 0, 0, 0, 12'h001, 0, 0, 0));
        tbl.push_back(mk("bwr_004", 0, 1, 13'h004, 1, 1, 16'h1277,
                         0, 0, 0, 0, 0, 1, 0, 12'h002, 8'h77, 0, 16'h2211));
        tbl.push_back(mk("both_cpu", 0, 1, 13'h002, 0, 0, 0,
                         1, 13'h006, 8'h33, 0, 0, 0, 0, 12'h001, 0, 0, 0));
        tbl.push_back(mk("idle3", 0, 0, 13'h000, 0, 0, 0,
                         0, 0, 0, 0, 0, 0, 0, 12'h000, 0, 0, 16'h2211));
        tbl.push_back(mk("wrd_odd", 0, 1, 13'h005, 0, 0, 0,
                         0, 0, 0, 0, 0, 0, 0, 12'h002, 0, 0, 0));
        tbl.push_back(mk("idle4", 0, 0, 13'h000, 0, 0, 0,
                         0, 0, 0, 0, 0, 0, 0, 12'h000, 0, 0, 16'h0077));
        foreach (tbl[i]) step(tbl[i]);

        // Loader starved behind a continuous CPU reader.
        for (int i = 0; i < 4; i++) begin
            v = mk("starve_a", 0, 1, 13'h002, 0, 0, 0, 1, 13'h008, 8'h44,
                   0, 0, 0, 0, 12'h001, 0, 0, (i == 0) ? 16'h0 : 16'h2211);
            step(v);
        end
        step(mk("forced_a", 0, 1, 13'h002, 0, 0, 0, 1, 13'h008, 8'h44,
                1, 1, 1, 0, 12'h004, 8'h44, 0, 16'h2211));
        for (int i = 0; i < 4; i++) begin
            v = mk("starve_b", 0, 1, 13'h002, 0, 0, 0, 1, 13'h009, 8'h66,
                   0, 0, 0, 0, 12'h001, 0, 0, (i == 0) ? 16'h0 : 16'h2211);
            step(v);
        end
        step(mk("forced_b", 0, 1, 13'h002, 0, 0, 0, 1, 13'h009, 8'h66,
                1, 1, 0, 1, 12'h004, 0, 8'h66, 16'h2211));
        step(mk("post_idle", 0, 0, 13'h000, 0, 0, 0, 0, 0, 0,
                0, 0, 0, 0, 12'h000, 0, 0, 0));
        step(mk("wrd_008", 0, 1, 13'h008, 0, 0, 0, 0, 0, 0,
                0, 0, 0, 0, 12'h004, 0, 0, 0));
        step(mk("ldr_data", 0, 0, 13'h000, 0, 0, 0, 0, 0, 0,
                0, 0, 0, 0, 12'h000, 0, 0, 16'h6644));

        // Reset in the middle of a pending loader request and a CPU read.
        step(mk("pre_rst", 0, 1, 13'h300, 0, 0, 0, 0, 0, 0,
                0, 0, 0, 0, 12'h180, 0, 0, 0));
        step(mk("mid_rst", 1, 1, 13'h300, 0, 0, 0, 1, 13'h00A, 8'h55,
                0, 0, 0, 0, 12'h180, 0, 0, 0));
        step(mk("after_rst", 0, 0, 13'h000, 0, 0, 0, 1, 13'h00A, 8'h55,
                0, 1, 1, 0, 12'h005, 8'h55, 0, 0));
        step(mk("ack_once", 0, 0, 13'h000, 0, 0, 0, 0, 0, 0,
                0, 0, 0, 0, 12'h000, 0, 0, 0));
        step(mk("brd_00A", 0, 1, 13'h00A, 0, 1, 0, 0, 0, 0,
                0, 0, 0, 0, 12'h005, 0, 0, 0));
        step(mk("rst_data", 0, 0, 13'h000, 0, 0, 0, 0, 0, 0,
                0, 0, 0, 0, 12'h000, 0, 0, 16'h0055));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
